// File: rtl/mux_scan_seq.sv
// Registered N:1 data multiplexer with manual, auto-scan (dwell-timed) and hold modes.
// Optional per-channel enable mask: define MUX_SCAN_MASK_EN to add the chan_mask input.
module mux_scan_seq #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1000,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       chan_mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      switched
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [SEL_W-1:0]    sel_next;
  logic [SEL_W-1:0]    adv_sel;
  logic [CHANNELS-1:0] enabled;
  logic                req_ok;
  logic                load;
  logic [WIDTH-1:0]    chan [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef MUX_SCAN_MASK_EN
  assign enabled = chan_mask;
`else
  assign enabled = '1;
`endif

  // First enabled channel cyclically above cur; cur itself if no other channel is enabled.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                    input logic [CHANNELS-1:0] en);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] k;
    int               idx;
    res = cur;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      idx = int'(cur) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      k = SEL_W'(idx);
      if (en[k]) res = k;
    end
    return res;
  endfunction

  assign adv_sel = next_enabled(sel_out, enabled);
  assign req_ok  = ({1'b0, sel_in} < (SEL_W+1)'(CHANNELS)) && enabled[sel_in];

  always_comb begin
    case (mode)
      2'b00:   next_state = MANUAL;
      2'b01:   next_state = AUTO;
      default: next_state = HOLD;
    endcase
  end

  // The counter only advances while staying in AUTO; any entry or exit clears it,
  // so a mode change always wins over a dwell expiry of the old mode.
  always_comb begin
    sel_next = sel_out;
    cnt_next = '0;
    load     = 1'b1;
    case (next_state)
      MANUAL: begin
        if (req_ok) sel_next = sel_in;
      end
      AUTO: begin
        if (state == AUTO) begin
          if (cnt == CNT_LAST) begin
            sel_next = adv_sel;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= MANUAL;
      cnt      <= '0;
      sel_out  <= '0;
      y        <= '0;
      switched <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      sel_out  <= sel_next;
      switched <= (sel_next != sel_out);
      if (load) y <= chan[sel_next];
    end
  end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq (WIDTH=16, CHANNELS=4, DWELL=4): directed test plan plus random mode/data traffic.
module tb_mux_scan_seq;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] data_in;
  logic [1:0]  mode;
  logic [1:0]  sel_in;
`ifdef MUX_SCAN_MASK_EN
  logic [3:0]  chan_mask;
`endif
  logic [15:0] y;
  logic [1:0]  sel_out;
  logic        switched;

  mux_scan_seq #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .mode     (mode),
    .sel_in   (sel_in),
`ifdef MUX_SCAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .y        (y),
    .sel_out  (sel_out),
    .switched (switched)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] y;
    logic [1:0]  sel;
    logic        sw;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pulses;

  // Reference model: 0 manual, 1 auto, 2 hold
  int          m_state = 0;
  int          m_cnt = 0;
  logic [1:0]  m_sel = 2'd0;
  logic [15:0] m_y = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] cur_mask();
`ifdef MUX_SCAN_MASK_EN
    return chan_mask;
`else
    return 4'hf;
`endif
  endfunction

  task automatic model_push();
    exp_t        e;
    int          ns;
    logic [1:0]  nsel;
    logic [3:0]  msk;
    logic [1:0]  k;
    msk = cur_mask();
    if (!reset_n) begin
      m_state = 0; m_cnt = 0; m_sel = 2'd0; m_y = 16'h0;
      e.sw = 1'b0;
    end else begin
      ns   = (mode == 2'b00) ? 0 : (mode == 2'b01) ? 1 : 2;
      nsel = m_sel;
      if (ns == 0 && msk[sel_in]) nsel = sel_in;
      if (ns == 1 && m_state == 1) begin
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          for (int i = 3; i >= 1; i--) begin
            k = m_sel + 2'(i);
            if (msk[k]) nsel = k;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 0;
      end
      if (ns != 2) m_y = data_in[nsel*16 +: 16];
      e.sw    = (nsel != m_sel);
      m_sel   = nsel;
      m_state = ns;
    end
    e.y   = m_y;
    e.sel = m_sel;
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    $display("cyc %0d rst_n=%b mode=%b sel_in=%0d -> y=%h sel_out=%0d switched=%b",
             cyc, reset_n, mode, sel_in, y, sel_out, switched);
    check("y", 32'(y), 32'(e.y));
    check("sel_out", 32'(sel_out), 32'(e.sel));
    check("switched", 32'(switched), 32'(e.sw));
    if (switched) pulses++;
  endtask

  task automatic set_chan(input int k, input logic [15:0] v);
    data_in[k*16 +: 16] = v;
  endtask

  initial begin
    data_in = {16'h5a5a, 16'ha5a5, 16'hffff, 16'h0000};
    mode    = 2'b01;
    sel_in  = 2'd0;
    reset_n = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    chan_mask = 4'hf;
`endif

    // 1: reset, then first advance four edges after the AUTO entry edge
    repeat (2) cycle();
    check("rst_y", 32'(y), 32'h0);
    check("rst_sel", 32'(sel_out), 32'h0);
    check("rst_sw", 32'(switched), 32'h0);
    reset_n = 1'b1;
    repeat (4) cycle();
    check("pre_adv_sel", 32'(sel_out), 32'h0);
    cycle();
    check("adv1_sel", 32'(sel_out), 32'h1);
    check("adv1_y", 32'(y), 32'hffff);
    check("adv1_sw", 32'(switched), 32'h1);
    cycle();
    check("adv1_sw_end", 32'(switched), 32'h0);

    // 2: manual select and live tracking
    mode = 2'b00; sel_in = 2'd2;
    cycle();
    check("man_y", 32'(y), 32'ha5a5);
    check("man_sw", 32'(switched), 32'h1);
    set_chan(2, 16'hcde3);
    cycle();
    check("man_track_y", 32'(y), 32'hcde3);
    check("man_track_sw", 32'(switched), 32'h0);
    set_chan(2, 16'ha5a5);
    cycle();

    // 3: auto wrap from channel 3, then a full scan
    sel_in = 2'd3;
    cycle();
    mode = 2'b01;
    repeat (5) cycle();
    check("wrap_sel", 32'(sel_out), 32'h0);
    check("wrap_y", 32'(y), 32'h0);
    pulses = 0;
    repeat (16) cycle();
    check("scan_pulses", 32'(pulses), 32'd4);
    check("scan_sel", 32'(sel_out), 32'h0);

    // 4: hold freezes y even while the source changes
    for (int i = 0; i < 40 && sel_out != 2'd2; i++) cycle();
    check("reach_sel2", 32'(sel_out), 32'h2);
    mode = 2'b10;
    set_chan(2, 16'h1234);
    pulses = 0;
    repeat (20) cycle();
    check("hold_y", 32'(y), 32'ha5a5);
    check("hold_pulses", 32'(pulses), 32'd0);
    mode = 2'b01;
    repeat (4) cycle();
    check("resume_pre_sel", 32'(sel_out), 32'h2);
    cycle();
    check("resume_sel", 32'(sel_out), 32'h3);
    check("resume_y", 32'(y), 32'h5a5a);
    set_chan(2, 16'ha5a5);

    // 5: reset mid-scan restarts the dwell
    for (int i = 0; i < 40 && sel_out != 2'd2; i++) cycle();
    repeat (2) cycle();
    reset_n = 1'b0;
    cycle();
    check("midrst_y", 32'(y), 32'h0);
    check("midrst_sel", 32'(sel_out), 32'h0);
    reset_n = 1'b1;
    repeat (3) cycle();
    check("midrst_nochg", 32'(sel_out), 32'h0);
    repeat (2) cycle();
    check("midrst_adv", 32'(sel_out), 32'h1);

`ifdef MUX_SCAN_MASK_EN
    // 6: masked scan, empty mask, masked manual request
    chan_mask = 4'b1010; mode = 2'b00; sel_in = 2'd1;
    cycle();
    mode = 2'b01;
    repeat (5) cycle();
    check("mask_sel3", 32'(sel_out), 32'h3);
    repeat (4) cycle();
    check("mask_sel1", 32'(sel_out), 32'h1);
    chan_mask = 4'b0000;
    pulses = 0;
    repeat (12) cycle();
    check("mask_zero_pulses", 32'(pulses), 32'd0);
    chan_mask = 4'b1010; mode = 2'b00; sel_in = 2'd0;
    cycle();
    check("mask_manual_ign", 32'(sel_out), 32'h1);
    chan_mask = 4'hf;
`endif

    // Random traffic against the scoreboard model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) set_chan(int'($urandom_range(0, 3)), 16'($urandom));
      reset_n = ($urandom_range(0, 40) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
Parametrised, registered N:1 data multiplexer with a built-in channel sequencer. It selects one of CHANNELS WIDTH-bit inputs by one of three modes:
- manual select
- automatic round-robin scan with a programmable dwell time
- freeze (hold)

The output is registered. The block sits between sampled data sources (switches, ADC results, counters) and the display/output path.

Parameters:
WIDTH, 16, bit width of each channel and of y
CHANNELS, 4, number of input channels (>= 2)
DWELL, 1000, clock cycles each channel is held in auto-scan (>= 1)
SEL_W (localparam), $clog2(CHANNELS), select width

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
data_in  input  CHANNELS*WIDTH  flattened channels; channel k = data_in[k*WIDTH +: WIDTH]
mode  input  2  00 manual, 01 auto-scan, 10 hold, 11 treated as hold
sel_in  input  SEL_W  channel request, used in manual mode only
y  output  WIDTH  registered selected data
sel_out  output  SEL_W  channel currently driving y
switched  output  1  one-cycle pulse when sel_out changes value

Behaviour:
- Reset (reset_n=0 at a rising clk):
  - y=0, sel_out=0, switched=0
  - dwell counter=0, state=MANUAL
  - Reset mid-scan aborts the scan immediately; no pulse is produced.
- States MANUAL/AUTO/HOLD:
  - The next state is decoded from mode every cycle; the transition takes effect on the next edge.
  - Mode 11 maps to HOLD.
- Latency:
  - y is 1 cycle from data_in/sel_in.
  - On the edge where sel_out takes a new value, y loads data_in of that new channel in the same edge, so y and sel_out are always consistent.
- MANUAL:
  - sel_out <= sel_in; y <= channel(sel_in).
  - If sel_in >= CHANNELS (non-power-of-2 CHANNELS), sel_out holds its value and y keeps tracking channel(sel_out).
- AUTO:
  - The counter runs 0..DWELL-1. When the count reaches DWELL-1, the counter wraps to 0 and sel_out advances cyclically (CHANNELS-1 -> 0).
  - Between advances, y <= channel(sel_out) every cycle, so live data is tracked.
  - DWELL=1 advances every cycle.
- HOLD:
  - sel_out, y and the counter are frozen.
  - y does NOT track data changes.
- Counter rules:
  - The counter clears on entry to AUTO and on any exit from AUTO.
  - After entering AUTO, the first advance occurs on the DWELL-th cycle spent in AUTO.
  - Scan resumes from the current sel_out, not from 0.
- switched:
  - High for exactly one cycle, aligned with the new sel_out value, whenever sel_out differs from its previous value (any mode).
  - Manual re-selection of the current channel produces no pulse.
- Simultaneous events:
  - A mode change takes priority over a pending dwell expiry: the old mode's advance is not performed.
  - Reset overrides everything.

Optional Feature:
Macro: MUX_SCAN_MASK_EN
- Defined:
  - Adds input chan_mask [CHANNELS-1:0]; a bit value of 1 means the channel is enabled.
  - AUTO advances to the next enabled channel cyclically above sel_out. If the only enabled channel is the current one, sel_out stays and no pulse occurs. If the mask is all zero, sel_out holds and no pulse occurs; the counter still wraps.
  - MANUAL requests for a masked channel are ignored (sel_out holds).
  - The mask is sampled every cycle; masking the current channel does not force a switch until the next advance.
- Undefined:
  - Port absent; all channels are treated as enabled.

Test Plan (WIDTH=16, CHANNELS=4, DWELL=4, channels 0..3 = 16'h0000, 16'hffff, 16'ha5a5, 16'h5a5a):
1. Hold reset_n=0 for 2 cycles with mode=01 -> y=16'h0000, sel_out=0, switched=0. Release -> first advance exactly 4 cycles later: sel_out=1, y=16'hffff, switched high 1 cycle.
2. Manual: mode=00, sel_in=2 -> next edge y=16'ha5a5, sel_out=2, switched=1. Then change channel 2 to 16'hcde3 -> y=16'hcde3 one cycle later, switched=0.
3. Auto wrap: mode=01 starting from sel_out=3 -> after 4 cycles sel_out=0, y=16'h0000. Full scan 0->1->2->3->0 takes 16 cycles with 4 switched pulses.
4. Hold: in AUTO at sel_out=2, set mode=10 for 20 cycles while channel 2 changes to 16'h1234 -> y stays 16'ha5a5, no pulses. Return to 01 -> advance to 3 after 4 more cycles.
5. Reset mid-scan: assert reset_n=0 at sel_out=2, counter=2 -> next edge y=0, sel_out=0. After release in AUTO, the advance occurs 4 cycles later, not 2.
6. (MUX_SCAN_MASK_EN) chan_mask=4'b1010, AUTO from sel_out=1 -> sequence 1,3,1,3 every 4 cycles. Mask 4'b0000 -> sel_out frozen, no pulses. Manual sel_in=0 with mask 4'b1010 -> ignored.
